axiburst_slave: RTL and testbench
=================================

# axiburst_slave

AXI4 memory-mapped burst responder with a private byte-enabled RAM. It is the slave-side counterpart of the axiburst master: it accepts INCR write and read bursts of up to 256 beats on a 64-bit data bus. It stores write data under byte strobes and returns stored data on reads. It replaces the external memory model in system benches and serves as a small on-chip scratch memory in designs.

## Interface
- ADDR_W, 32, address width
- DATA_W, 64, data width; byte count STRB_W = DATA_W/8
- MEM_DEPTH, 1024, RAM depth in DATA_W words; power of two
- aclk  in  1  clock, all logic rising-edge
- aresetn  in  1  reset, asynchronous, active-low
- s_awaddr  in  ADDR_W  write burst start address
- s_awlen  in  8  write beats minus one
- s_awvalid / s_awready  in / out  1  write address handshake
- s_wdata  in  DATA_W  write data
- s_wstrb  in  STRB_W  byte enables, bit i covers wdata[8i+7:8i]
- s_wlast  in  1  master's last-beat marker
- s_wvalid / s_wready  in / out  1  write data handshake
- s_bresp  out  2  write response
- s_bvalid / s_bready  out / in  1  write response handshake
- s_araddr  in  ADDR_W  read burst start address
- s_arlen  in  8  read beats minus one
- s_arvalid / s_arready  in / out  1  read address handshake
- s_rdata  out  DATA_W  read data
- s_rresp  out  2  always OKAY (2'b00)
- s_rlast  out  1  high on final read beat only
- s_rvalid / s_rready  out / in  1  read data handshake

## Operation
- Burst rules: INCR only, full-width beats. No size or burst ports.
- Word index: addr[$clog2(STRB_W) +: $clog2(MEM_DEPTH)]. Low bits are ignored. Upper bits alias, so 0x20000CC0 and 0x00000CC0 are the same word. The index increments by 1 per beat and wraps modulo MEM_DEPTH.
- Write FSM states and transitions:
  - W_IDLE, awready=1. The AW handshake latches the index and len, then goes to W_DATA.
  - W_DATA, wready=1. Each W handshake writes the enabled bytes, then increments the index and beat count. The beat where count==len goes to W_RESP.
  - W_RESP, bvalid=1. The B handshake returns to W_IDLE.
- Write termination: the burst always ends after exactly len+1 beats, regardless of wlast.
- bresp is SLVERR (2'b10) if wlast was high on any beat before the last, or low on the last beat. Otherwise it is OKAY.
- Read FSM states and transitions:
  - R_IDLE, arready=1. The AR handshake loads rdata from the start word, then goes to R_DATA.
  - R_DATA, rvalid=1. On an R handshake that is not the last beat, rdata loads the next word. On the last-beat handshake, return to R_IDLE.
- The read and write FSMs are fully independent and may run at the same time.
- Same-cycle write and read-load of the same word: the read returns the pre-write contents.
- Reset state: awready, wready, bvalid, arready, rvalid, rlast = 0; bresp, rresp, rdata = 0; FSMs in IDLE. RAM contents are not reset.
- Reset asserted mid-burst: the burst is abandoned. Beats already written stay in RAM. No response is issued.

## Timing
- awready and arready assert on the first rising edge after reset release.
- AW handshake at cycle N: wready=1 from N+1. With continuous wvalid, one beat per cycle.
- Last W handshake at M: bvalid=1 from M+1, held until bready.
- B handshake at K: awready=1 at K+1.
- AR handshake at N: rvalid=1 and rdata valid at N+1.
- With continuous rready, one beat per cycle. A len=15 burst completes in cycles N+1 to N+16.
- rready=0: rdata, rlast and rvalid hold stable.
- Last R handshake at K: arready=1 at K+1.
- All outputs are registered or decoded from registered state. No combinational path from any input to any ready or valid output.

## Structure
- Package axiburst_pkg holds:
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - the enums wr_state_t {W_IDLE, W_DATA, W_RESP} and rd_state_t {R_IDLE, R_DATA}.
- Sub-module axiburst_slave_ram: one write port with byte enables and one synchronous read port (read-before-write), MEM_DEPTH x DATA_W.

## Test plan
- Single-beat write to 0x10000000, data 0xF8F4F2F1, strb 0xFF, bready=1 -> bvalid one cycle after the W handshake, bresp=00. A len=0 read then returns 0x00000000F8F4F2F1 with rlast=1.
- 16-beat write to 0x10000080 with continuous wvalid (data 0x0A, 0xBA, ...) -> wready stays high, 16 beats in 16 cycles. A len=15 read with rready=1 gives rvalid at AR+1, 16 back-to-back beats in order, and rlast on beat 16 only.
- Byte-strobe writes:
  - Word 0x30001500 preloaded with all-ones, write 0xDEADBEEFDEADBEEF with strb 0x01 -> read 0xFFFFFFFFFFFFFFEF.
  - Word 0x30001540 preloaded with zero, write 0xBADCAFEEBADCAFEE with strb 0xAA -> read 0xBA00AF00BA00AF00.
- Read backpressure: len=3 burst with rready pattern 1,0,1,0,1,0,1 -> rdata and rvalid are stable during rready=0, 4 beats in order, and arready rises the cycle after the 4th handshake.
- Protocol error and aliasing:
  - len=3 write with wlast high on beat 2 -> 4 beats accepted, bresp=2'b10.
  - Write to 0x20000CC0, then read 0x00000CC0 -> same data.
- aresetn pulsed low during beat 5 of a 16-beat write -> all outputs 0 immediately. After release, awready=1 on the next edge. Beats 0-4 read back intact, beats 5-15 unchanged.

Source files
------------

// File: rtl/axiburst_pkg.sv
// Shared types and response codes for the AXI burst slave.
// No logic; constants and FSM encodings only.
// Backpressure: not applicable.
package axiburst_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

    // Beat progress within one burst: awlen/arlen and beats done so far.
    typedef struct packed {
        logic [7:0] len;
        logic [7:0] cnt;
    } beat_ctr_t;

endpackage

// File: rtl/axiburst_slave_ram.sv
// Byte-enabled single-write / single-read word RAM.
// Read latency 1 cycle, read-before-write on the same word.
// Backpressure: none, both ports accept every cycle.
module axiburst_slave_ram #(
    parameter  int DATA_W    = 64,
    parameter  int MEM_DEPTH = 1024,
    localparam int STRB_W    = DATA_W / 8,
    localparam int IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              wr_vld,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [STRB_W-1:0] wr_strb,
    input  logic              rd_vld,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge aclk) begin
        if (wr_vld) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_dat[8*i +: 8];
                end
            end
        end
    end

    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_dat <= '0;
        end else if (rd_vld) begin
            rd_dat <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/axiburst_slave.sv
// AXI4 INCR burst slave backed by a private byte-enabled RAM.
// Latency: wready at AW+1, bvalid at last W+1, rvalid/rdata at AR+1.
// Backpressure: rready low holds the R beat; bready low holds the B response.
module axiburst_slave
    import axiburst_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic [7:0]          s_awlen,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wlast,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [ADDR_W-1:0]   s_araddr,
    input  logic [7:0]          s_arlen,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rlast,
    output logic                s_rvalid,
    input  logic                s_rready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int OFF_W  = $clog2(STRB_W);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    // Upper address bits alias and sub-word bits are ignored.
    logic unused_addr;
    assign unused_addr = ^{s_awaddr, s_araddr};

    // Holds ready outputs low until the first edge after reset release.
    logic rst_done;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rst_done <= 1'b0;
        else          rst_done <= 1'b1;
    end

    // ---------------- write side ----------------
    wr_state_t        wr_state, wr_next;
    logic [IDX_W-1:0] w_idx;
    beat_ctr_t        w_ctr;
    logic             w_err;
    logic             aw_hs, w_hs, b_hs, w_final;

    assign aw_hs   = s_awvalid & s_awready;
    assign w_hs    = s_wvalid & s_wready;
    assign b_hs    = s_bvalid & s_bready;
    assign w_final = (w_ctr.cnt == w_ctr.len);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) wr_state <= W_IDLE;
        else          wr_state <= wr_next;
    end

    always_comb begin
        wr_next = wr_state;
        unique case (wr_state)
            W_IDLE:  if (aw_hs)           wr_next = W_DATA;
            W_DATA:  if (w_hs && w_final) wr_next = W_RESP;
            W_RESP:  if (b_hs)            wr_next = W_IDLE;
            default:                      wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        s_bresp   = RESP_OKAY;
        unique case (wr_state)
            W_IDLE: s_awready = rst_done;
            W_DATA: s_wready  = 1'b1;
            W_RESP: begin
                s_bvalid = 1'b1;
                s_bresp  = w_err ? RESP_SLVERR : RESP_OKAY;
            end
            default: ;
        endcase
    end

    // Burst length comes from awlen alone; wlast only feeds the error flag.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_idx <= '0;
            w_ctr <= '0;
            w_err <= 1'b0;
        end else if (aw_hs) begin
            w_idx     <= s_awaddr[OFF_W +: IDX_W];
            w_ctr.len <= s_awlen;
            w_ctr.cnt <= 8'd0;
            w_err     <= 1'b0;
        end else if (w_hs) begin
            w_idx     <= w_idx + IDX_ONE;
            w_ctr.cnt <= w_ctr.cnt + 8'd1;
            if (s_wlast != w_final) w_err <= 1'b1;
        end
    end

    // ---------------- read side ----------------
    rd_state_t        rd_state, rd_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] ar_idx;
    beat_ctr_t        r_ctr;
    logic             ar_hs, r_hs, r_final;
    logic             ram_rd_vld;
    logic [IDX_W-1:0] ram_rd_idx;

    assign ar_idx  = s_araddr[OFF_W +: IDX_W];
    assign ar_hs   = s_arvalid & s_arready;
    assign r_hs    = s_rvalid & s_rready;
    assign r_final = (r_ctr.cnt == r_ctr.len);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rd_state <= R_IDLE;
        else          rd_state <= rd_next;
    end

    always_comb begin
        rd_next = rd_state;
        unique case (rd_state)
            R_IDLE:  if (ar_hs)           rd_next = R_DATA;
            R_DATA:  if (r_hs && r_final) rd_next = R_IDLE;
            default:                      rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rlast   = 1'b0;
        s_rresp   = RESP_OKAY;
        unique case (rd_state)
            R_IDLE: s_arready = rst_done;
            R_DATA: begin
                s_rvalid = 1'b1;
                s_rlast  = r_final;
            end
            default: ;
        endcase
    end

    // r_idx always points at the word to prefetch for the next beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_idx <= '0;
            r_ctr <= '0;
        end else if (ar_hs) begin
            r_idx     <= ar_idx + IDX_ONE;
            r_ctr.len <= s_arlen;
            r_ctr.cnt <= 8'd0;
        end else if (r_hs && !r_final) begin
            r_idx     <= r_idx + IDX_ONE;
            r_ctr.cnt <= r_ctr.cnt + 8'd1;
        end
    end

    assign ram_rd_vld = ar_hs | (r_hs & ~r_final);
    assign ram_rd_idx = ar_hs ? ar_idx : r_idx;

    axiburst_slave_ram #(
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_ram (
        .aclk    (aclk),
        .aresetn (aresetn),
        .wr_vld  (w_hs),
        .wr_idx  (w_idx),
        .wr_dat  (s_wdata),
        .wr_strb (s_wstrb),
        .rd_vld  (ram_rd_vld),
        .rd_idx  (ram_rd_idx),
        .rd_dat  (s_rdata)
    );

endmodule

// File: tb/tb_axiburst_slave.sv
// Bench for axiburst_slave: transaction-level memory model plus per-cycle compare.
module tb_axiburst_slave;

    localparam int DEPTH = 1024;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] s_awaddr = '0;
    logic [7:0]  s_awlen = '0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [63:0] s_wdata = '0;
    logic [7:0]  s_wstrb = '0;
    logic        s_wlast = 1'b0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b0;
    logic [31:0] s_araddr = '0;
    logic [7:0]  s_arlen = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [63:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        s_rvalid;
    logic        s_rready = 1'b0;

    axiburst_slave dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got no handshake within bound, want handshake", name);
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a >> 3) % DEPTH;
    endfunction

    // ---------------- reference model ----------------
    logic [63:0] mmem [DEPTH];
    int          w_left = 0;
    int          w_ptr = 0;
    bit          w_bad = 1'b0;
    bit          b_pend = 1'b0;
    logic [63:0] rd_q [$];
    logic [63:0] got_q [$];
    bit          live = 1'b0;
    int          cyc = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) live <= 1'b0;
        else          live <= 1'b1;
    end

    always @(negedge aclk) begin : cmp
        bit ea, ear;
        if (!aresetn) begin
            chk("rst_awready", s_awready, 0);
            chk("rst_wready",  s_wready, 0);
            chk("rst_bvalid",  s_bvalid, 0);
            chk("rst_bresp",   s_bresp, 0);
            chk("rst_arready", s_arready, 0);
            chk("rst_rvalid",  s_rvalid, 0);
            chk("rst_rlast",   s_rlast, 0);
            chk("rst_rdata",   s_rdata, 0);
            chk("rst_rresp",   s_rresp, 0);
            w_left = 0;
            b_pend = 1'b0;
            rd_q.delete();
        end else begin
            ea  = live && (w_left == 0) && !b_pend;
            ear = live && (rd_q.size() == 0);
            chk("awready", s_awready, ea);
            chk("wready",  s_wready, w_left > 0);
            chk("bvalid",  s_bvalid, b_pend);
            if (b_pend) chk("bresp", s_bresp, w_bad ? 2'b10 : 2'b00);
            chk("arready", s_arready, ear);
            chk("rvalid",  s_rvalid, rd_q.size() > 0);
            if (rd_q.size() > 0) begin
                chk("rdata", s_rdata, rd_q[0]);
                chk("rlast", s_rlast, rd_q.size() == 1);
                chk("rresp", s_rresp, 0);
                if (s_rready) begin
                    got_q.push_back(s_rdata);
                    void'(rd_q.pop_front());
                end
            end
            // Read snapshot precedes this cycle's write: same-word reads see old data.
            if (s_arvalid && ear) begin
                for (int k = 0; k <= int'(s_arlen); k++)
                    rd_q.push_back(mmem[(widx(s_araddr) + k) % DEPTH]);
            end
            if (b_pend && s_bready) b_pend = 1'b0;
            if (s_wvalid && w_left > 0) begin
                for (int i = 0; i < 8; i++)
                    if (s_wstrb[i]) mmem[w_ptr][8*i +: 8] = s_wdata[8*i +: 8];
                if (s_wlast != (w_left == 1)) w_bad = 1'b1;
                w_ptr = (w_ptr + 1) % DEPTH;
                w_left--;
                if (w_left == 0) b_pend = 1'b1;
            end
            if (s_awvalid && ea) begin
                w_ptr  = widx(s_awaddr);
                w_left = int'(s_awlen) + 1;
                w_bad  = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [63:0] wd [256];
    logic [7:0]  ws [256];

    task automatic wr_burst(input logic [31:0] a, input int len, input int bad_beat, input bit gaps,
                            output logic [1:0] resp, output int c0, output int c1, output int cb);
        int n;
        resp = 2'b11; c0 = 0; c1 = 0; cb = 0;
        s_awaddr = a; s_awlen = 8'(len); s_awvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!s_awready && n < 200);
        if (!s_awready) begin tmo("aw_timeout"); s_awvalid = 1'b0; return; end
        @(posedge aclk); #1;
        s_awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            if (gaps) begin
                s_wvalid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
            end
            s_wvalid = 1'b1; s_wdata = wd[b]; s_wstrb = ws[b];
            s_wlast  = (bad_beat >= 0) ? (b == bad_beat) : (b == len);
            n = 0;
            do begin @(negedge aclk); n++; end while (!s_wready && n < 200);
            if (!s_wready) begin tmo("w_timeout"); s_wvalid = 1'b0; return; end
            if (b == 0) c0 = cyc;
            if (b == len) c1 = cyc;
            @(posedge aclk); #1;
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
        if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge aclk); #1; end
        s_bready = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!s_bvalid && n < 200);
        if (!s_bvalid) begin tmo("b_timeout"); s_bready = 1'b0; return; end
        resp = s_bresp; cb = cyc;
        @(posedge aclk); #1;
        s_bready = 1'b0;
    endtask

    // mode 0: rready always high, 1: 1,0,1,0..., 2: random
    task automatic rd_burst(input logic [31:0] a, input int len, input int mode,
                            output int car, output int rf, output int rl);
        int n, got;
        car = 0; rf = 0; rl = 0;
        s_araddr = a; s_arlen = 8'(len); s_arvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!s_arready && n < 200);
        if (!s_arready) begin tmo("ar_timeout"); s_arvalid = 1'b0; return; end
        car = cyc;
        @(posedge aclk); #1;
        s_arvalid = 1'b0;
        got = 0; n = 0;
        while (got <= len && n < 2000) begin
            s_rready = (mode == 0) ? 1'b1 : (mode == 1) ? (n % 2 == 0) : 1'($urandom_range(0, 1));
            @(negedge aclk);
            if (s_rvalid && s_rready) begin
                if (got == 0) rf = cyc;
                rl = cyc;
                got++;
            end
            n++;
            @(posedge aclk); #1;
        end
        s_rready = 1'b0;
        if (got <= len) tmo("r_timeout");
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    initial begin : main
        logic [1:0]  resp, resp2;
        int          c0, c1, cb, car, rf, rl, x0, x1, x2, y0, y1, y2;
        int          len, s, bad;
        logic [31:0] a;
        logic [63:0] e;

        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_awready_direct", s_awready, 0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("awready_before_edge", s_awready, 0);
        @(posedge aclk); #1;
        chk("awready_first_edge", s_awready, 1);
        chk("arready_first_edge", s_arready, 1);

        // single beat
        wd[0] = 64'hF8F4F2F1; ws[0] = 8'hFF;
        wr_burst(32'h10000000, 0, -1, 1'b0, resp, c0, c1, cb);
        chk("t1_bresp", resp, 2'b00);
        chk("t1_b_latency", cb, c1 + 1);
        chk("t1_model_word", mmem[widx(32'h10000000)], 64'h00000000F8F4F2F1);
        got_q.delete();
        rd_burst(32'h10000000, 0, 0, car, rf, rl);
        chk("t1_rd_beats", got_q.size(), 1);
        if (got_q.size() > 0) chk("t1_rdata", got_q[0], 64'h00000000F8F4F2F1);

        // 16-beat continuous burst
        for (int b = 0; b < 16; b++) begin wd[b] = 64'h0A + 64'(b) * 64'hB0; ws[b] = 8'hFF; end
        wr_burst(32'h10000080, 15, -1, 1'b0, resp, c0, c1, cb);
        chk("t2_w_cycles", c1 - c0, 15);
        chk("t2_bresp", resp, 2'b00);
        got_q.delete();
        rd_burst(32'h10000080, 15, 0, car, rf, rl);
        chk("t2_first_r", rf, car + 1);
        chk("t2_last_r", rl, car + 16);
        chk("t2_rd_beats", got_q.size(), 16);
        chk("t2_beat1_literal", (got_q.size() > 1) ? got_q[1] : 64'hX, 64'hBA);
        for (int b = 0; b < 16 && b < got_q.size(); b++) chk("t2_rdata", got_q[b], 64'h0A + 64'(b) * 64'hB0);

        // byte strobes
        wd[0] = '1; ws[0] = 8'hFF;
        wr_burst(32'h30001500, 0, -1, 1'b0, resp, c0, c1, cb);
        wd[0] = 64'hDEADBEEFDEADBEEF; ws[0] = 8'h01;
        wr_burst(32'h30001500, 0, -1, 1'b0, resp, c0, c1, cb);
        got_q.delete();
        rd_burst(32'h30001500, 0, 0, car, rf, rl);
        if (got_q.size() > 0) chk("t3_strb01", got_q[0], 64'hFFFFFFFFFFFFFFEF);
        else tmo("t3_strb01_nodata");
        wd[0] = '0; ws[0] = 8'hFF;
        wr_burst(32'h30001540, 0, -1, 1'b0, resp, c0, c1, cb);
        wd[0] = 64'hBADCAFEEBADCAFEE; ws[0] = 8'hAA;
        wr_burst(32'h30001540, 0, -1, 1'b0, resp, c0, c1, cb);
        got_q.delete();
        rd_burst(32'h30001540, 0, 0, car, rf, rl);
        if (got_q.size() > 0) chk("t3_strbAA", got_q[0], 64'hBA00AF00BA00AF00);
        else tmo("t3_strbAA_nodata");

        // read backpressure
        got_q.delete();
        rd_burst(32'h10000080, 3, 1, car, rf, rl);
        chk("t4_rd_beats", got_q.size(), 4);
        chk("t4_last_r", rl, car + 7);
        for (int b = 0; b < 4 && b < got_q.size(); b++) chk("t4_rdata", got_q[b], 64'h0A + 64'(b) * 64'hB0);

        // wlast error and aliasing
        for (int b = 0; b < 4; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
        wr_burst(32'h50000000, 3, 2, 1'b0, resp, c0, c1, cb);
        chk("t5_bresp_err", resp, 2'b10);
        chk("t5_beats", c1 - c0, 3);
        wd[0] = 64'h0123456789ABCDEF; ws[0] = 8'hFF;
        wr_burst(32'h20000CC0, 0, -1, 1'b0, resp, c0, c1, cb);
        got_q.delete();
        rd_burst(32'h00000CC0, 0, 0, car, rf, rl);
        if (got_q.size() > 0) chk("t6_alias", got_q[0], 64'h0123456789ABCDEF);
        else tmo("t6_alias_nodata");

        // independent read and write streams on disjoint words
        for (int b = 0; b < 16; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
        got_q.delete();
        fork
            wr_burst(32'h60000000, 15, -1, 1'b1, resp2, x0, x1, x2);
            rd_burst(32'h10000080, 15, 2, y0, y1, y2);
        join
        chk("t7_bresp", resp2, 2'b00);
        chk("t7_rd_beats", got_q.size(), 16);
        for (int b = 0; b < 16 && b < got_q.size(); b++) chk("t7_rdata", got_q[b], 64'h0A + 64'(b) * 64'hB0);

        // reset during a burst
        for (int b = 0; b < 16; b++) begin wd[b] = 64'h1111000000000000 | 64'(b); ws[b] = 8'hFF; end
        wr_burst(32'h40000000, 15, -1, 1'b0, resp, c0, c1, cb);
        s_awaddr = 32'h40000000; s_awlen = 8'd15; s_awvalid = 1'b1;
        @(negedge aclk);
        @(posedge aclk); #1;
        s_awvalid = 1'b0;
        for (int b = 0; b < 5; b++) begin
            s_wvalid = 1'b1; s_wdata = 64'h2222000000000000 | 64'(b); s_wstrb = 8'hFF; s_wlast = 1'b0;
            @(negedge aclk);
            @(posedge aclk); #1;
        end
        s_wdata = 64'h2222000000000005;
        aresetn = 1'b0;
        #1;
        chk("t8_rst_wready", s_wready, 0);
        chk("t8_rst_awready", s_awready, 0);
        chk("t8_rst_rdata", s_rdata, 0);
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        s_wvalid = 1'b0;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("t8_awready_after", s_awready, 1);
        got_q.delete();
        rd_burst(32'h40000000, 15, 2, car, rf, rl);
        chk("t8_rd_beats", got_q.size(), 16);
        for (int b = 0; b < 16 && b < got_q.size(); b++)
            chk("t8_rdata", got_q[b], (b < 5) ? (64'h2222000000000000 | 64'(b)) : (64'h1111000000000000 | 64'(b)));

        // random phase over a wrapping 256-word window
        for (int b = 0; b < 256; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
        wr_burst(32'h00001C00, 255, -1, 1'b0, resp, c0, c1, cb);
        chk("t9_max_burst_cycles", c1 - c0, 255);
        for (int it = 0; it < 25; it++) begin
            len = $urandom_range(0, 15);
            s = (896 + $urandom_range(0, 255 - len)) % DEPTH;
            a = (32'($urandom_range(0, 15)) << 28) | 32'(s << 3) | 32'($urandom_range(0, 7));
            for (int b = 0; b <= len; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'($urandom); end
            bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
            wr_burst(a, len, bad, 1'b1, resp, c0, c1, cb);
            len = $urandom_range(0, 15);
            s = (896 + $urandom_range(0, 255 - len)) % DEPTH;
            a = (32'($urandom_range(0, 15)) << 28) | 32'(s << 3) | 32'($urandom_range(0, 7));
            rd_burst(a, len, 2, car, rf, rl);
        end

        repeat (3) @(posedge aclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
